fp32_mul_pipe: RTL and testbench

//  Pipelined IEEE-754 binary32 multiplier: fpmult = x * y. Unpacks operands, XORs signs,

---
 rtl/fp32_mul_pipe.sv | 199 +++++++++++++++++++
 tb/tb_fp32_mul_pipe.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_pipe.sv
// Pipelined IEEE-754 binary32 multiplier, round-to-nearest-even, subnormals flushed to zero.
// Rank 1 unpack/classify, rank 2 significand product, rank 3 normalise, rank 4 round/pack.
module fp32_mul_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        out_valid,
    output logic [31:0] fpmult,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned MANT_W = 24;
    localparam int unsigned PROD_W = 48;
    localparam int unsigned ESUM_W = 10;

    localparam logic signed [ESUM_W-1:0] BIAS    = 10'sd127;
    localparam logic signed [ESUM_W-1:0] EXP_MAX = 10'sd255;
    localparam logic signed [ESUM_W-1:0] EXP_MIN = 10'sd0;
    localparam logic [31:0]              QNAN    = 32'h7FC0_0000;

    // unpack and classify
    logic [EXP_W-1:0]         ex_c, ey_c;
    logic [FRAC_W-1:0]        fx_c, fy_c;
    logic                     x_nan_c, y_nan_c, x_inf_c, y_inf_c, x_zero_c, y_zero_c;
    logic                     inv_c, inf_c, zero_c;
    logic [MANT_W-1:0]        ma_c, mb_c;
    logic signed [ESUM_W-1:0] esum_c;

    always_comb begin
        ex_c     = x[30:23];
        ey_c     = y[30:23];
        fx_c     = x[22:0];
        fy_c     = y[22:0];
        x_nan_c  = (ex_c == '1) && (fx_c != '0);
        y_nan_c  = (ey_c == '1) && (fy_c != '0);
        x_inf_c  = (ex_c == '1) && (fx_c == '0);
        y_inf_c  = (ey_c == '1) && (fy_c == '0);
        x_zero_c = (ex_c == '0);
        y_zero_c = (ey_c == '0);
        inv_c    = x_nan_c || y_nan_c || (x_inf_c && y_zero_c) || (y_inf_c && x_zero_c);
        inf_c    = !inv_c && (x_inf_c || y_inf_c);
        zero_c   = !inv_c && !inf_c && (x_zero_c || y_zero_c);
        ma_c     = x_zero_c ? '0 : {1'b1, fx_c};
        mb_c     = y_zero_c ? '0 : {1'b1, fy_c};
        esum_c   = $signed({2'b00, ex_c}) + $signed({2'b00, ey_c}) - BIAS;
    end

    logic                     s1_valid, s1_sign, s1_inv, s1_inf, s1_zero;
    logic [MANT_W-1:0]        s1_ma, s1_mb;
    logic signed [ESUM_W-1:0] s1_esum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_inv   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_ma    <= '0;
            s1_mb    <= '0;
            s1_esum  <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_sign  <= x[31] ^ y[31];
            s1_inv   <= inv_c;
            s1_inf   <= inf_c;
            s1_zero  <= zero_c;
            s1_ma    <= ma_c;
            s1_mb    <= mb_c;
            s1_esum  <= esum_c;
        end
    end

    // significand product
    logic                     s2_valid, s2_sign, s2_inv, s2_inf, s2_zero;
    logic [PROD_W-1:0]        s2_p;
    logic signed [ESUM_W-1:0] s2_esum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_inv   <= 1'b0;
            s2_inf   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_p     <= '0;
            s2_esum  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_inv   <= s1_inv;
            s2_inf   <= s1_inf;
            s2_zero  <= s1_zero;
            s2_p     <= PROD_W'(s1_ma) * PROD_W'(s1_mb);
            s2_esum  <= s1_esum;
        end
    end

    // normalise: product of two [1,2) significands lies in [1,4)
    logic [FRAC_W-1:0]        nfrac_c;
    logic                     nguard_c, nsticky_c;
    logic signed [ESUM_W-1:0] nexp_c;

    always_comb begin
        nfrac_c   = s2_p[45:23];
        nguard_c  = s2_p[22];
        nsticky_c = |s2_p[21:0];
        nexp_c    = s2_esum;
        if (s2_p[47]) begin
            nfrac_c   = s2_p[46:24];
            nguard_c  = s2_p[23];
            nsticky_c = |s2_p[22:0];
            nexp_c    = s2_esum + 10'sd1;
        end
    end

    logic                     s3_valid, s3_sign, s3_inv, s3_inf, s3_zero;
    logic                     s3_guard, s3_sticky;
    logic [FRAC_W-1:0]        s3_frac;
    logic signed [ESUM_W-1:0] s3_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid  <= 1'b0;
            s3_sign   <= 1'b0;
            s3_inv    <= 1'b0;
            s3_inf    <= 1'b0;
            s3_zero   <= 1'b0;
            s3_guard  <= 1'b0;
            s3_sticky <= 1'b0;
            s3_frac   <= '0;
            s3_exp    <= '0;
        end else begin
            s3_valid  <= s2_valid;
            s3_sign   <= s2_sign;
            s3_inv    <= s2_inv;
            s3_inf    <= s2_inf;
            s3_zero   <= s2_zero;
            s3_guard  <= nguard_c;
            s3_sticky <= nsticky_c;
            s3_frac   <= nfrac_c;
            s3_exp    <= nexp_c;
        end
    end

    // round to nearest even, then resolve specials and range
    logic                     rinc_c;
    logic [MANT_W-1:0]        rsum_c;
    logic signed [ESUM_W-1:0] rexp_c;
    logic [31:0]              res_c;
    logic                     ovf_c, unf_c, inv_out_c;

    always_comb begin
        rinc_c    = s3_guard && (s3_sticky || s3_frac[0]);
        rsum_c    = {1'b0, s3_frac} + MANT_W'(rinc_c);
        rexp_c    = s3_exp + $signed({9'b0, rsum_c[MANT_W-1]});
        res_c     = {s3_sign, rexp_c[EXP_W-1:0], rsum_c[FRAC_W-1:0]};
        ovf_c     = 1'b0;
        unf_c     = 1'b0;
        inv_out_c = 1'b0;
        if (s3_inv) begin
            res_c     = QNAN;
            inv_out_c = 1'b1;
        end else if (s3_inf) begin
            res_c = {s3_sign, 8'hFF, 23'h0};
        end else if (s3_zero) begin
            res_c = {s3_sign, 31'h0};
        end else if (rexp_c >= EXP_MAX) begin
            res_c = {s3_sign, 8'hFF, 23'h0};
            ovf_c = 1'b1;
        end else if (rexp_c <= EXP_MIN) begin
            res_c = {s3_sign, 31'h0};
            unf_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            fpmult    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            out_valid <= s3_valid;
            fpmult    <= res_c;
            overflow  <= ovf_c;
            underflow <= unf_c;
            invalid   <= inv_out_c;
        end
    end

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Directed bench for fp32_mul_pipe: hand-computed products, flags, 3-cycle latency,
// back-to-back issue and asynchronous reset with operations in flight.
module tb_fp32_mul_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] x;
    logic [31:0] y;
    logic        out_valid;
    logic [31:0] fpmult;
    logic        overflow;
    logic        underflow;
    logic        invalid;

    fp32_mul_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .fpmult    (fpmult),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [2:0]  f;   // {overflow, underflow, invalid}
    } vec_t;

    typedef struct {
        int          idx;
        int unsigned due;
        logic [31:0] r;
        logic [2:0]  f;
    } exp_t;

    localparam int NV = 19;
    vec_t vecs [NV] = '{
        '{32'hBE99999A, 32'h43FA2000, 32'hC3161334, 3'b000},
        '{32'h40000000, 32'h40400000, 32'h40C00000, 3'b000},
        '{32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000},
        '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100},
        '{32'h00800000, 32'h00800000, 32'h00000000, 3'b010},
        '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001},
        '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000},
        '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000},
        '{32'hC0000000, 32'hC0400000, 32'h40C00000, 3'b000},
        '{32'h80000000, 32'h40400000, 32'h80000000, 3'b000},
        '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001},
        '{32'h00000001, 32'h3F800000, 32'h00000000, 3'b000},
        '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000},
        '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 3'b100},
        '{32'h00800000, 32'h3F000000, 32'h00000000, 3'b010},
        '{32'h00800000, 32'h3F800000, 32'h00800000, 3'b000},
        '{32'h3F7FFFFF, 32'h3F7FFFFF, 32'h3F7FFFFE, 3'b000},
        '{32'h7F800000, 32'hFF800000, 32'hFF800000, 3'b000},
        '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 3'b000}
    };

    exp_t q[$];

    // Scoreboard: every out_valid must match the oldest pending op, on its due cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check($sformatf("v%0d_result", e.idx), fpmult, e.r);
                check($sformatf("v%0d_flags", e.idx), 32'({overflow, underflow, invalid}), 32'(e.f));
                check($sformatf("v%0d_latency", e.idx), 32'(cyc), 32'(e.due));
            end
        end
    end

    // Called just after a negedge: the op is sampled at the next rising edge.
    task automatic drive(input int i);
        exp_t e;
        in_valid = 1'b1;
        x        = vecs[i].a;
        y        = vecs[i].b;
        e.idx    = i;
        e.due    = cyc + 1 + 3;
        e.r      = vecs[i].r;
        e.f      = vecs[i].f;
        q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check(tag, 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fpmult", fpmult, 32'd0);
        check("rst_flags", 32'({overflow, underflow, invalid}), 32'd0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // isolated first op to pin latency
        drive(0);
        @(negedge clk);
        in_valid = 1'b0;
        drain("drain_single");

        // back-to-back stream of all remaining vectors
        @(negedge clk);
        for (int i = 1; i < NV; i++) begin
            drive(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain("drain_stream");

        // reset with two ops in flight: outputs clear at once, nothing emitted afterwards
        @(negedge clk);
        drive(1);
        @(negedge clk);
        drive(2);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_fpmult", fpmult, 32'd0);
        check("midrst_flags", 32'({overflow, underflow, invalid}), 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // pipeline still works after the reset
        @(negedge clk);
        drive(7);
        @(negedge clk);
        in_valid = 1'b0;
        drain("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
